// File: rtl/fft_r22sdf_reorder_pkg.sv
// Shared FFT definitions: sample type, reader state encoding, clog2 and bit-reversal helpers.
// Used by the reorder stage and the BF/twiddle stages alike.
package fft_r22sdf_reorder_pkg;

  localparam int FFT_DATA_WIDTH = 25;

  typedef struct packed {
    logic signed [FFT_DATA_WIDTH-1:0] re;
    logic signed [FFT_DATA_WIDTH-1:0] im;
  } fft_sample_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_e;

  function automatic int fft_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Reverses the low 'w' bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_r22sdf_reorder_ram.sv
// Simple dual-port RAM for the reorder ping-pong buffer: one write port, one read port
// with a registered output. Contents are never reset so the array maps onto block RAM.
module fft_reorder_ram #(
  parameter int WIDTH = 50,
  parameter int AW    = 11
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(2**AW)-1];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_r22sdf_reorder.sv
// R2^2SDF output reorder: bit-reversed frames in, natural-order N-cycle bursts out.
// Define FFT_REORDER_SYNC_EN to add the sync_i frame-alignment input.
module fft_r22sdf_reorder
  import fft_r22sdf_reorder_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int N          = 1024,
  parameter int LOG2N      = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
`ifdef FFT_REORDER_SYNC_EN
  input  logic                  sync_i,
`endif
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_re_i,
  input  logic [DATA_WIDTH-1:0] data_im_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_re_o,
  output logic [DATA_WIDTH-1:0] data_im_o,
  output logic [LOG2N-1:0]      idx_o
);

  localparam int AW = LOG2N + 1;
  localparam int SW = 2 * DATA_WIDTH;

  if (fft_clog2(N) != LOG2N || (1 << LOG2N) != N || N < 4) begin : g_param_check
    $fatal(1, "fft_r22sdf_reorder: N must be a power of 2 >= 4 and LOG2N must equal log2(N)");
  end

  logic             sync_w;
`ifdef FFT_REORDER_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  logic [LOG2N-1:0] wr_ctr_q, wr_ctr_d;
  logic             wr_bank_q, wr_bank_d;
  logic [31:0]      wr_rev;
  logic [AW-1:0]    wr_addr;
  logic             full_w;
  logic             full_bank_w;

  rd_state_e        state_q, state_d;
  logic [LOG2N-1:0] rd_ctr_q, rd_ctr_d;
  logic             rd_bank_q, rd_bank_d;
  logic             rd_en;

  logic             vld_p1_q, vld_p1_d;
  logic [LOG2N-1:0] idx_p1_q, idx_p1_d;
  logic [SW-1:0]    ram_rdata;

  logic                  valid_q, valid_d;
  logic [LOG2N-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_re_q, data_re_d;
  logic [DATA_WIDTH-1:0] data_im_q, data_im_d;

  assign wr_rev = bitrev({{(32-LOG2N){1'b0}}, wr_ctr_q}, LOG2N);

  // Writer: bit-reversed scatter into the active bank, bank flip on the last sample.
  always_comb begin
    wr_ctr_d    = wr_ctr_q;
    wr_bank_d   = wr_bank_q;
    full_w      = 1'b0;
    full_bank_w = wr_bank_q;
    wr_addr     = {wr_bank_q, wr_rev[LOG2N-1:0]};
    if (valid_i) begin
      if (sync_w) begin
        // A sync sample restarts the current bank at position 0 without flipping it.
        wr_addr  = {wr_bank_q, {LOG2N{1'b0}}};
        wr_ctr_d = LOG2N'(1);
      end else if (wr_ctr_q == LOG2N'(N - 1)) begin
        full_w    = 1'b1;
        wr_bank_d = ~wr_bank_q;
        wr_ctr_d  = '0;
      end else begin
        wr_ctr_d = wr_ctr_q + LOG2N'(1);
      end
    end
  end

  // Reader: rd_ctr_q/rd_bank_q form the registered read address while in BURST.
  always_comb begin
    state_d   = state_q;
    rd_ctr_d  = rd_ctr_q;
    rd_bank_d = rd_bank_q;
    rd_en     = (state_q == RD_BURST);
    unique case (state_q)
      RD_IDLE: begin
        if (full_w) begin
          state_d   = RD_BURST;
          rd_ctr_d  = '0;
          rd_bank_d = full_bank_w;
        end
      end
      RD_BURST: begin
        if (rd_ctr_q == LOG2N'(N - 1)) begin
          if (full_w) begin
            rd_ctr_d  = '0;
            rd_bank_d = full_bank_w;
          end else begin
            state_d = RD_IDLE;
          end
        end else begin
          rd_ctr_d = rd_ctr_q + LOG2N'(1);
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  fft_reorder_ram #(
    .WIDTH (SW),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (valid_i),
    .waddr_i (wr_addr),
    .wdata_i ({data_re_i, data_im_i}),
    .re_i    (rd_en),
    .raddr_i ({rd_bank_q, rd_ctr_q}),
    .rdata_o (ram_rdata)
  );

  // Stage p1: RAM output register, index and valid travel alongside.
  always_comb begin
    vld_p1_d = rd_en;
    idx_p1_d = idx_p1_q;
    if (rd_en) idx_p1_d = rd_ctr_q;
  end

  // Output stage: registered outputs hold their last values between bursts.
  always_comb begin
    valid_d   = vld_p1_q;
    idx_d     = idx_q;
    data_re_d = data_re_q;
    data_im_d = data_im_q;
    if (vld_p1_q) begin
      idx_d     = idx_p1_q;
      data_re_d = ram_rdata[SW-1:DATA_WIDTH];
      data_im_d = ram_rdata[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ctr_q  <= '0;
      wr_bank_q <= 1'b0;
      state_q   <= RD_IDLE;
      rd_ctr_q  <= '0;
      rd_bank_q <= 1'b0;
      vld_p1_q  <= 1'b0;
      idx_p1_q  <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      data_re_q <= '0;
      data_im_q <= '0;
    end else begin
      wr_ctr_q  <= wr_ctr_d;
      wr_bank_q <= wr_bank_d;
      state_q   <= state_d;
      rd_ctr_q  <= rd_ctr_d;
      rd_bank_q <= rd_bank_d;
      vld_p1_q  <= vld_p1_d;
      idx_p1_q  <= idx_p1_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      data_re_q <= data_re_d;
      data_im_q <= data_im_d;
    end
  end

  assign valid_o   = valid_q;
  assign idx_o     = idx_q;
  assign data_re_o = data_re_q;
  assign data_im_o = data_im_q;

endmodule
